uart_tx_arbiter: RTL
====================

// Module: uart_tx_arbiter
// PURPOSE
//  Shares one uart_transmitter between P_NUM_REQ byte sources. Round-robin arbitration
//  with packet lock: once a source wins, it keeps the grant until it sends a byte
//  flagged LAST. Sequences the transmitter: one-cycle TX_ENABLE, then waits for
//  TX_BUSY to rise and fall. Flags a transmitter that never goes busy.
// PARAMETERS
//  P_NUM_REQ       4  number of requesters (>=2)
//  P_BUSY_TIMEOUT  4  cycles in S_WAIT_BUSY before the byte is declared lost (>=1)
// PORTS
//  i_CLK        in   1          single clock; all state on posedge
//  i_RESET      in   1          asynchronous, active-high reset
//  i_REQ_VALID  in   N          per-requester byte valid
//  i_REQ_DATA   in   8*N        byte k at [8k+7:8k]
//  i_REQ_LAST   in   N          byte k ends requester k's packet (releases lock)
//  o_REQ_READY  out  N          combinational; transfer on edge where VALID&READY
//  o_GRANT      out  N          one-hot current owner (zero when none)
//  o_TX_ENABLE  out  1          to transmitter i_TX_ENABLE; one-cycle pulse
//  o_TX_DATA    out  8          to transmitter i_DATA_IN; registered byte
//  i_TX_BUSY    in   1          from transmitter o_TX_BUSY
//  o_ACTIVE     out  1          high whenever state != S_ARB
//  o_ERROR      out  1          one-cycle pulse on busy timeout
// BEHAVIOUR
//  Reset (async, any time incl. mid-frame): state S_ARB, rr pointer = N-1, lock clear,
//   owner 0, r_DATA 0, timeout counter 0; all outputs 0. In-flight byte abandoned.
//  FSM: S_ARB -> S_LAUNCH -> S_WAIT_BUSY -> S_WAIT_DONE -> S_ARB.
//  S_ARB: if i_TX_BUSY=1, no READY (transmitter in use). Else winner =
//   locked ? owner : first k with VALID, searching ptr+1, ptr+2,... mod N.
//   READY[winner]=1 only if VALID[winner]; all other READY=0.
//   On transfer: r_DATA<=byte, owner<=k, ptr<=k, lock<=!LAST[k], -> S_LAUNCH.
//   Locked and owner not valid: wait in S_ARB; no other requester served.
//  S_LAUNCH: o_TX_ENABLE=1 for exactly this cycle; -> S_WAIT_BUSY.
//  S_WAIT_BUSY: busy=1 -> S_WAIT_DONE. Else count; after P_BUSY_TIMEOUT cycles
//   without busy: o_ERROR pulse, lock cleared, byte dropped, -> S_ARB.
//  S_WAIT_DONE: busy=0 -> S_ARB.
//  o_TX_DATA = r_DATA; stable from S_LAUNCH through S_WAIT_DONE.
//  o_GRANT = onehot(owner) when state!=S_ARB or lock set; else 0.
//  Timing (transmitter busy B=10 cycles): accept edge t, ENABLE in t+1, busy t+2..t+11,
//   back in S_ARB at t+13; byte-to-byte period = B+3 = 13 cycles.
//  Simultaneous VALIDs unlocked: lowest index after ptr wins; ptr wraps N-1 -> 0.
//  VALID dropping before READY: no transfer, no state change.
//  Timeout counter is reset on entry to S_WAIT_BUSY; width ceil(log2(P_BUSY_TIMEOUT+1)).
// TESTING
//  Reset, REQ_VALID=4'b1111, LAST=1 -> grant order 0,1,2,3,0; one ENABLE per 13 cycles.
//  Req1 sends 0xA5,0x3C,0x7E (LAST on 3rd) while req0,2 valid -> all 3 bytes from req1
//   on o_TX_DATA consecutively, then req2 granted.
//  Locked owner drops VALID 20 cycles, others valid -> stays S_ARB, GRANT unchanged.
//  Hold i_TX_BUSY=0 after ENABLE -> o_ERROR pulses 4 cycles into S_WAIT_BUSY, lock clears.
//  i_TX_BUSY=1 in S_ARB with req0 valid -> READY stays 0 until busy falls.
//  Assert i_RESET during S_WAIT_DONE -> all outputs 0 same cycle, next grant req0.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// Round-robin, packet-locking arbiter that shares one UART transmitter among
// P_NUM_REQ byte sources and sequences its enable/busy handshake.
module uart_tx_arbiter #(
    parameter int unsigned P_NUM_REQ      = 4,
    parameter int unsigned P_BUSY_TIMEOUT = 4
) (
    input  logic                     i_CLK,
    input  logic                     i_RESET,
    input  logic [P_NUM_REQ-1:0]     i_REQ_VALID,
    input  logic [8*P_NUM_REQ-1:0]   i_REQ_DATA,
    input  logic [P_NUM_REQ-1:0]     i_REQ_LAST,
    output logic [P_NUM_REQ-1:0]     o_REQ_READY,
    output logic [P_NUM_REQ-1:0]     o_GRANT,
    output logic                     o_TX_ENABLE,
    output logic [7:0]               o_TX_DATA,
    input  logic                     i_TX_BUSY,
    output logic                     o_ACTIVE,
    output logic                     o_ERROR
);

    localparam int unsigned IDX_W = (P_NUM_REQ > 1) ? $clog2(P_NUM_REQ) : 1;
    localparam int unsigned CNT_W = $clog2(P_BUSY_TIMEOUT + 1);

    typedef enum logic [1:0] {
        S_ARB       = 2'd0,
        S_LAUNCH    = 2'd1,
        S_WAIT_BUSY = 2'd2,
        S_WAIT_DONE = 2'd3
    } state_t;

    state_t                 state_q;
    logic [IDX_W-1:0]       ptr_q;
    logic [IDX_W-1:0]       owner_q;
    logic                   lock_q;
    logic [7:0]             data_q;
    logic [CNT_W-1:0]       cnt_q;
    logic                   tx_en_q;
    logic                   error_q;
    logic                   active_q;
    logic [P_NUM_REQ-1:0]   grant_q;

    logic                   win_found_c;
    logic [IDX_W-1:0]       win_idx_c;
    logic [7:0]             win_data_c;
    logic                   win_last_c;
    logic [P_NUM_REQ-1:0]   win_onehot_c;
    logic                   xfer_c;

    // Winner selection: locked owner, else first valid requester after ptr.
    always_comb begin
        int unsigned j;
        win_found_c  = 1'b0;
        win_idx_c    = owner_q;
        win_onehot_c = '0;
        j            = 0;
        if (lock_q) begin
            win_found_c = i_REQ_VALID[owner_q];
        end else begin
            for (int unsigned i = 1; i <= P_NUM_REQ; i++) begin
                j = 32'(ptr_q) + i;
                if (j >= P_NUM_REQ) begin
                    j = j - P_NUM_REQ;
                end
                if (!win_found_c && i_REQ_VALID[IDX_W'(j)]) begin
                    win_found_c = 1'b1;
                    win_idx_c   = IDX_W'(j);
                end
            end
        end
        win_data_c              = i_REQ_DATA[{win_idx_c, 3'b000} +: 8];
        win_last_c              = i_REQ_LAST[win_idx_c];
        win_onehot_c[win_idx_c] = 1'b1;
    end

    assign xfer_c      = (state_q == S_ARB) && !i_TX_BUSY && win_found_c;
    assign o_REQ_READY = xfer_c ? win_onehot_c : '0;

    always_ff @(posedge i_CLK or posedge i_RESET) begin
        if (i_RESET) begin
            state_q  <= S_ARB;
            ptr_q    <= IDX_W'(P_NUM_REQ - 1);
            owner_q  <= '0;
            lock_q   <= 1'b0;
            data_q   <= '0;
            cnt_q    <= '0;
            tx_en_q  <= 1'b0;
            error_q  <= 1'b0;
            active_q <= 1'b0;
            grant_q  <= '0;
        end else begin
            tx_en_q <= 1'b0;
            error_q <= 1'b0;
            case (state_q)
                S_ARB: begin
                    if (xfer_c) begin
                        data_q   <= win_data_c;
                        owner_q  <= win_idx_c;
                        ptr_q    <= win_idx_c;
                        lock_q   <= !win_last_c;
                        grant_q  <= win_onehot_c;
                        tx_en_q  <= 1'b1;
                        active_q <= 1'b1;
                        state_q  <= S_LAUNCH;
                    end
                end
                S_LAUNCH: begin
                    cnt_q   <= '0;
                    state_q <= S_WAIT_BUSY;
                end
                S_WAIT_BUSY: begin
                    if (i_TX_BUSY) begin
                        state_q <= S_WAIT_DONE;
                    end else if (cnt_q == CNT_W'(P_BUSY_TIMEOUT - 1)) begin
                        // Transmitter never accepted the byte: drop it and free the lock.
                        error_q  <= 1'b1;
                        lock_q   <= 1'b0;
                        grant_q  <= '0;
                        active_q <= 1'b0;
                        state_q  <= S_ARB;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                S_WAIT_DONE: begin
                    if (!i_TX_BUSY) begin
                        active_q <= 1'b0;
                        if (!lock_q) begin
                            grant_q <= '0;
                        end
                        state_q <= S_ARB;
                    end
                end
                default: state_q <= S_ARB;
            endcase
        end
    end

    assign o_GRANT     = grant_q;
    assign o_TX_ENABLE = tx_en_q;
    assign o_TX_DATA   = data_q;
    assign o_ACTIVE    = active_q;
    assign o_ERROR     = error_q;

endmodule
